// File: rtl/ysyx_23060061_pkg.sv
// Shared types and constants for the ysyx_23060061 instruction fetch unit.
package ysyx_23060061_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } ifu_state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060061_ifu_perf.sv
// Fetch performance counters: delivered instructions and stalled fetch cycles.
// Both counters are 32-bit, reset to zero and wrap on overflow.
module ysyx_23060061_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  // Count handshakes and stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_inc) perf_fetched <= perf_fetched + 32'd1;
      if (stall_inc) perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and
// hands each instruction to decode over a valid/ready handshake.
// Optional counters are enabled with `define YSYX_23060061_IFU_PERF_EN.
module ysyx_23060061_ifu #(
  parameter logic [31:0] RESET_PC = ysyx_23060061_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef YSYX_23060061_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  import ysyx_23060061_pkg::*;

  ifu_state_t  state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic        cap;
  logic [31:0] target;
  logic [31:0] seq_pc;

  // Low address bits of a redirect are dropped; masking keeps every bit in use
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign seq_pc = pc + 32'd4;

  assign req_valid  = (state == REQ);
  assign req_addr   = pc;
  assign inst_valid = (state == HOLD);

  // Next-state, next-PC and kill logic
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    cap     = 1'b0;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (redirect_valid) pc_n = target;
        if (req_ready) begin
          state_n = WAIT;
          kill_n  = redirect_valid;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n   = target;
          kill_n = 1'b1;
        end
        // A redirect arriving together with the response also kills it
        if (rsp_valid) begin
          kill_n = 1'b0;
          if (kill || redirect_valid) begin
            state_n = REQ;
          end else begin
            cap     = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          pc_n    = redirect_valid ? target : seq_pc;
          state_n = REQ;
        end else if (redirect_valid) begin
          pc_n    = target;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, PC and kill registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
    end
  end

  // Instruction output registers, loaded when a live response arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else if (cap) begin
      inst       <= rsp_data;
      inst_pc    <= pc;
      inst_fault <= rsp_err;
    end
  end

`ifdef YSYX_23060061_IFU_PERF_EN
  ysyx_23060061_ifu_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .fetch_inc    (inst_valid && inst_ready),
    .stall_inc    ((state == REQ && !req_ready) || (state == WAIT && !rsp_valid)),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Self-checking bench for ysyx_23060061_ifu with a behavioural memory and
// an instruction-stream reference model.
module tb_ysyx_23060061_ifu;
  import ysyx_23060061_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef YSYX_23060061_IFU_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [31:0] stall0;
`endif

  always #5 clk = ~clk;

  ysyx_23060061_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef YSYX_23060061_IFU_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // memory model
  bit          busy;
  int          cnt;
  logic [31:0] pend;
  bit          poison;
  bit          spur_en;
  // reference model
  logic [31:0] exp_pc;
  bit          watch_dead;
  bit          prev_hold_wait;
  logic [31:0] prev_inst, prev_pc;
  logic        prev_fault;
  int unsigned cyc, hs_cnt, stall_cnt, last_hs_cyc, hs_gap;
  logic [31:0] acc_q[$];
  logic [31:0] hs_q[$];
  logic [31:0] h_inst, h_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    if (a == 32'h8000_0004) return 32'h0020_0113;
    if (a == 32'h0000_0000) return INST_NOP;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic memerr(input logic [31:0] a);
    return a[5:2] == 4'd2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory/decode/execute inputs, check, advance.
  task automatic step(input bit rr, input int lat, input bit ir, input bit rv,
                      input logic [31:0] rpc);
    bit          rsp_now, spur;
    logic [31:0] tgt;
    rsp_now = busy && cnt == 0;
    spur    = spur_en && !busy && ($urandom_range(0, 7) == 0);
    rsp_valid      = rsp_now || spur;
    rsp_data       = rsp_now ? (poison ? 32'hDEAD_BEEF : memword(pend)) : $urandom();
    rsp_err        = rsp_now ? memerr(pend) : 1'($urandom_range(0, 1));
    req_ready      = rr && !busy && !spur;
    inst_ready     = ir;
    redirect_valid = rv;
    redirect_pc    = rpc;
    tgt            = rpc & 32'hFFFF_FFFC;
    #1;
    if (watch_dead && inst_valid) chkb("killed_not_shown", inst === 32'hDEAD_BEEF, 1'b0);
    if (prev_hold_wait) begin
      chkb("hold_valid", inst_valid, 1'b1);
      chk("hold_inst", inst, prev_inst);
      chk("hold_pc", inst_pc, prev_pc);
      chkb("hold_fault", inst_fault, prev_fault);
    end
    if (req_valid && req_ready) begin
      chk("req_addr", req_addr, exp_pc);
      acc_q.push_back(req_addr);
    end
    if ((req_valid && !req_ready) || (busy && !rsp_now)) stall_cnt++;
    if (inst_valid && inst_ready) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, memword(exp_pc));
      chkb("inst_fault", inst_fault, memerr(exp_pc));
      hs_q.push_back(inst_pc);
      hs_cnt++;
      hs_gap      = cyc - last_hs_cyc;
      last_hs_cyc = cyc;
      exp_pc      = rv ? tgt : exp_pc + 32'd4;
    end else if (rv) begin
      exp_pc = tgt;
    end
    prev_hold_wait = inst_valid && !ir && !rv;
    prev_inst      = inst;
    prev_pc        = inst_pc;
    prev_fault     = inst_fault;
    if (rsp_now) begin
      busy   = 0;
      poison = 0;
    end else if (busy) begin
      cnt--;
    end
    if (req_valid && req_ready) begin
      busy = 1;
      cnt  = lat;
      pend = req_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy   = 0;
    cnt    = 0;
    poison = 0;
    #1;
    chkb("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_addr", req_addr, RESET_PC);
    chkb("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chkb("rst_inst_fault", inst_fault, 1'b0);
`ifdef YSYX_23060061_IFU_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_stall", perf_stall, 32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    exp_pc         = RESET_PC;
    prev_hold_wait = 0;
    hs_cnt         = 0;
    stall_cnt      = 0;
    last_hs_cyc    = cyc;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (req_valid !== 1'b1 && n < 30) begin
      step(0, 0, 1, 0, 32'h0);
      n++;
    end
    chkb("reach_req", req_valid, 1'b1);
  endtask

  initial begin
    cyc = 0;
    spur_en = 0;
    watch_dead = 0;
    do_reset();

    // zero-wait fetch of two words, one per 3 cycles
    chkb("idle_no_req", req_valid, 1'b0);
    step(1, 0, 1, 0, 32'h0);
    chkb("first_req_valid", req_valid, 1'b1);
    chk("first_req_addr", req_addr, 32'h8000_0000);
    repeat (6) step(1, 0, 1, 0, 32'h0);
    chk("acc_count", 32'(acc_q.size()), 32'd2);
    chk("acc0", acc_q[0], 32'h8000_0000);
    chk("acc1", acc_q[1], 32'h8000_0004);
    chk("hs0", hs_q[0], 32'h8000_0000);
    chk("hs1", hs_q[1], 32'h8000_0004);
    chk("throughput", hs_gap, 32'd3);

    // request not accepted for 4 cycles
`ifdef YSYX_23060061_IFU_PERF_EN
    stall0 = perf_stall;
`endif
    repeat (4) begin
      chkb("stall_req_valid", req_valid, 1'b1);
      chk("stall_req_addr", req_addr, 32'h8000_0008);
      chkb("stall_no_inst", inst_valid, 1'b0);
      step(0, 0, 1, 0, 32'h0);
    end
`ifdef YSYX_23060061_IFU_PERF_EN
    chk("perf_stall4", perf_stall - stall0, 32'd4);
`endif

    // access fault at 0x80000008, clean word at 0x8000000C
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    chkb("fault_valid", inst_valid, 1'b1);
    chkb("fault_flag", inst_fault, 1'b1);
    chk("fault_pc", inst_pc, 32'h8000_0008);
    step(1, 0, 1, 0, 32'h0);
    chk("after_fault_addr", req_addr, 32'h8000_000C);
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    chkb("nofault_flag", inst_fault, 1'b0);
    chk("nofault_pc", inst_pc, 32'h8000_000C);
    step(1, 0, 1, 0, 32'h0);

    // redirect during WAIT kills the pending response
    poison = 1;
    watch_dead = 1;
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 1, 1, 32'h8000_0100);
    step(1, 0, 1, 0, 32'h0);
    chkb("kill_no_inst", inst_valid, 1'b0);
    chkb("kill_req_valid", req_valid, 1'b1);
    chk("kill_req_addr", req_addr, 32'h8000_0100);
    repeat (3) step(1, 0, 1, 0, 32'h0);
    watch_dead = 0;

    // decode stalls in HOLD, redirect on the third cycle drops the word
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    h_inst = inst;
    h_pc   = inst_pc;
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("hold_stable_inst", inst, h_inst);
    chk("hold_stable_pc", inst_pc, h_pc);
    step(0, 0, 0, 1, 32'h8000_0043);
    chkb("drop_inst_valid", inst_valid, 1'b0);
    chkb("drop_req_valid", req_valid, 1'b1);
    chk("drop_req_addr", req_addr, 32'h8000_0040);

    // 32-bit PC wrap-around
    step(0, 0, 1, 1, 32'hFFFF_FFFF);
    chk("wrap_req_addr", req_addr, 32'hFFFF_FFFC);
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    chk("wrap_next_addr", req_addr, 32'h0000_0000);

    // randomized traffic against the reference model
    spur_en = 1;
    repeat (400) begin
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, r);
    end
    spur_en = 0;
    chkb("random_progress", hs_cnt > 20, 1'b1);
`ifdef YSYX_23060061_IFU_PERF_EN
    chk("perf_fetched", perf_fetched, hs_cnt);
    chk("perf_stall", perf_stall, stall_cnt);
`endif

    // asynchronous reset in the middle of WAIT
    wait_req();
    step(1, 2, 1, 0, 32'h0);
    chkb("wait_no_req", req_valid, 1'b0);
    do_reset();
    chkb("post_rst_idle", req_valid, 1'b0);
    step(1, 0, 1, 0, 32'h0);
    chkb("post_rst_req_valid", req_valid, 1'b1);
    chk("post_rst_req_addr", req_addr, 32'h8000_0000);
    repeat (9) step(1, $urandom_range(0, 1), 1, 0, 32'h0);
    chkb("post_rst_progress", hs_cnt >= 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
